// File: rtl/fpu_writeback_buffer.sv
// FP writeback buffer: queues completed FPU results in a small FIFO, drains
// one per cycle into the FP register file write port, and tracks pending FP
// destinations so issue logic can stall on RAW/WAW hazards.
module fpu_writeback_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  f_rs1,
    input  logic [4:0]  f_rs2,
    output logic        hazard,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_data,
    input  logic [4:0]  res_rd,
    input  logic [4:0]  res_flags,
    output logic [31:0] f_w_data,
    output logic [4:0]  f_rd,
    output logic        f_wen,
    output logic        f_NV,
    output logic        f_DZ,
    output logic        f_OF,
    output logic        f_UF,
    output logic        f_NX,
    output logic        err_unexpected
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pending_q, pending_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   mem_data_q  [DEPTH];
    logic [31:0]   mem_data_d  [DEPTH];
    logic [4:0]    mem_rd_q    [DEPTH];
    logic [4:0]    mem_rd_d    [DEPTH];
    logic [4:0]    mem_flags_q [DEPTH];
    logic [4:0]    mem_flags_d [DEPTH];
    logic [31:0]   w_data_q, w_data_d;
    logic [4:0]    w_rd_q, w_rd_d;
    logic [4:0]    w_flags_q, w_flags_d;
    logic          wen_q, wen_d;
    logic          err_q, err_d;
    logic          issue_fire, push, pop, retire;

    // Handshakes and hazard detection, all combinational from current state
    always_comb begin
        issue_ready = (outstanding_q < DEPTH_C) && !pending_q[issue_rd] && !RST && !flush;
        hazard      = pending_q[f_rs1] || pending_q[f_rs2];
        res_ready   = (count_q < DEPTH_C);
        issue_fire  = issue_valid && issue_ready;
        // a result offered during a flush is dropped
        push        = res_valid && res_ready && !flush;
        pop         = (count_q != '0);
        retire      = wen_q;
    end

    // Next-state for scoreboard, FIFO and output stage
    always_comb begin
        pending_d = pending_q;
        if (retire) pending_d[w_rd_q] = 1'b0;
        if (issue_fire) pending_d[issue_rd] = 1'b1;

        // floor at zero so a stray (unexpected) result cannot underflow
        outstanding_d = outstanding_q;
        case ({issue_fire, retire && (outstanding_q != '0)})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        mem_data_d  = mem_data_q;
        mem_rd_d    = mem_rd_q;
        mem_flags_d = mem_flags_q;
        tail_d      = tail_q;
        if (push) begin
            mem_data_d[tail_q]  = res_data;
            mem_rd_d[tail_q]    = res_rd;
            mem_flags_d[tail_q] = res_flags;
            tail_d              = tail_q + 1'b1;
        end

        head_d    = head_q;
        wen_d     = 1'b0;
        w_flags_d = 5'd0;
        w_data_d  = w_data_q;
        w_rd_d    = w_rd_q;
        if (pop) begin
            head_d    = head_q + 1'b1;
            wen_d     = 1'b1;
            w_data_d  = mem_data_q[head_q];
            w_rd_d    = mem_rd_q[head_q];
            w_flags_d = mem_flags_q[head_q];
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        err_d = err_q || (push && !pending_q[res_rd]);
    end

    // Control and output-stage registers; flush clears the same as reset
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            wen_q         <= 1'b0;
            w_data_q      <= 32'd0;
            w_rd_q        <= 5'd0;
            w_flags_q     <= 5'd0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            wen_q         <= wen_d;
            w_data_q      <= w_data_d;
            w_rd_q        <= w_rd_d;
            w_flags_q     <= w_flags_d;
        end
    end

    // Sticky unexpected-result flag survives flush, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    // FIFO storage needs no reset: entries are only read when counted valid
    always_ff @(posedge CLK) begin
        mem_data_q  <= mem_data_d;
        mem_rd_q    <= mem_rd_d;
        mem_flags_q <= mem_flags_d;
    end

    assign f_w_data       = w_data_q;
    assign f_rd           = w_rd_q;
    assign f_wen          = wen_q;
    assign f_NV           = w_flags_q[4];
    assign f_DZ           = w_flags_q[3];
    assign f_OF           = w_flags_q[2];
    assign f_UF           = w_flags_q[1];
    assign f_NX           = w_flags_q[0];
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_fpu_writeback_buffer.sv
// Randomized bench for fpu_writeback_buffer with a timeline-based reference
// model: each accepted result is scheduled to write at max(t+2, prev+1).
module tb_fpu_writeback_buffer;
    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST, flush, issue_valid, res_valid;
    logic [4:0]  issue_rd, f_rs1, f_rs2, res_rd, res_flags;
    logic [31:0] res_data;
    logic        issue_ready, hazard, res_ready, f_wen, err_unexpected;
    logic        f_NV, f_DZ, f_OF, f_UF, f_NX;
    logic [31:0] f_w_data;
    logic [4:0]  f_rd;

    always #5 CLK = ~CLK;

    fpu_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .f_rs1(f_rs1), .f_rs2(f_rs2), .hazard(hazard),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_flags(res_flags),
        .f_w_data(f_w_data), .f_rd(f_rd), .f_wen(f_wen),
        .f_NV(f_NV), .f_DZ(f_DZ), .f_OF(f_OF), .f_UF(f_UF), .f_NX(f_NX),
        .err_unexpected(err_unexpected)
    );

    typedef struct {
        int          wc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } wr_t;

    wr_t         sched[$];
    int          fpuq[$];
    bit [31:0]   pend;
    int          outs;
    bit          err_m;
    logic [31:0] last_data;
    logic [4:0]  last_rd;
    int          last_w;
    int          cyc;
    int          n_chk = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int fifo_cnt();
        int n = 0;
        foreach (sched[i]) if (sched[i].wc > cyc) n++;
        return n;
    endfunction

    task automatic model_clear();
        sched.delete();
        fpuq.delete();
        pend = '0;
        outs = 0;
        last_data = 32'd0;
        last_rd = 5'd0;
        last_w = -100;
    endtask

    // check outputs mid-cycle, then advance the model across the clock edge
    task automatic step();
        bit wr_now, exp_ir, exp_rr, pend_rd;
        int w;
        @(negedge CLK);
        wr_now = (sched.size() > 0) && (sched[0].wc == cyc);
        exp_ir = !RST && !flush && (outs < DEPTH) && !pend[issue_rd];
        exp_rr = fifo_cnt() < DEPTH;
        check("f_wen", f_wen, wr_now);
        check("f_w_data", f_w_data, wr_now ? sched[0].data : last_data);
        check("f_rd", f_rd, wr_now ? sched[0].rd : last_rd);
        check("flags", {f_NV, f_DZ, f_OF, f_UF, f_NX}, wr_now ? sched[0].flags : 5'd0);
        check("hazard", hazard, pend[f_rs1] || pend[f_rs2]);
        check("issue_ready", issue_ready, exp_ir);
        check("res_ready", res_ready, exp_rr);
        check("err_unexpected", err_unexpected, err_m);
        if (RST || flush) begin
            model_clear();
            if (RST) err_m = 1'b0;
        end else begin
            pend_rd = pend[res_rd];
            if (wr_now) begin
                last_data = sched[0].data;
                last_rd = sched[0].rd;
                pend[sched[0].rd] = 1'b0;
                if (outs > 0) outs--;
                void'(sched.pop_front());
            end
            if (issue_valid && exp_ir) begin
                pend[issue_rd] = 1'b1;
                outs++;
                fpuq.push_back(int'(issue_rd));
            end
            if (res_valid && exp_rr) begin
                if (!pend_rd) err_m = 1'b1;
                w = (cyc + 2 > last_w + 1) ? cyc + 2 : last_w + 1;
                sched.push_back('{w, res_data, res_rd, res_flags});
                last_w = w;
                if (fpuq.size() > 0 && fpuq[0] == int'(res_rd)) void'(fpuq.pop_front());
            end
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; flush = 1'b0; issue_valid = 1'b0; res_valid = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        idle(); issue_valid = 1'b1; issue_rd = rd; step();
    endtask

    task automatic do_res(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] fl);
        idle(); res_valid = 1'b1; res_rd = rd; res_data = d; res_flags = fl; step();
    endtask

    // return results for everything still in flight, then let it drain
    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            idle();
            if (fpuq.size() > 0) begin
                res_valid = 1'b1; res_rd = 5'(fpuq[0]);
                res_data = $urandom; res_flags = 5'($urandom);
            end
            step();
        end
    endtask

    initial begin
        idle();
        RST = 1'b1; issue_rd = 5'd0; f_rs1 = 5'd0; f_rs2 = 5'd0;
        res_rd = 5'd0; res_data = 32'd0; res_flags = 5'd0;
        @(posedge CLK); #1;
        cyc = 0; err_m = 1'b0; model_clear();
        // reset state, with an issue attempt that must be refused
        issue_valid = 1'b1; issue_rd = 5'd4; step();

        // single op with hazard watch on rs1=5
        f_rs1 = 5'd5; f_rs2 = 5'd9;
        do_issue(5'd5);
        idle(); step();
        do_res(5'd5, 32'h3F800000, 5'b00001);
        idle(); repeat (5) step();

        // outstanding limit and WAW stall
        do_issue(5'd1);
        do_issue(5'd2);
        do_issue(5'd3);
        do_issue(5'd1);
        do_res(5'd1, 32'h11111111, 5'b10000);
        do_res(5'd2, 32'h22222222, 5'b01000);
        for (int i = 0; i < 6; i++) begin
            idle(); issue_valid = 1'b1; issue_rd = 5'd3; f_rs1 = 5'd3; step();
        end
        drain();

        // back-to-back pairs, exercising pointer wrap
        for (int k = 0; k < 5; k++) begin
            f_rs1 = 5'd1; f_rs2 = 5'd2;
            do_issue(5'd1);
            do_issue(5'd2);
            do_res(5'd1, 32'hA0000000 + k, 5'(k));
            do_res(5'd2, 32'hB0000000 + k, 5'(k + 8));
            idle(); repeat (4) step();
        end

        // flush while the output stage is writing, with a result that must drop
        do_issue(5'd1);
        do_issue(5'd2);
        do_res(5'd1, 32'hC1C1C1C1, 5'b00011);
        do_res(5'd2, 32'hC2C2C2C2, 5'b00101);
        idle(); flush = 1'b1; res_valid = 1'b1; res_rd = 5'd2; step();
        for (int i = 0; i < 8; i++) begin
            idle(); f_rs1 = 5'(i); f_rs2 = 5'(i + 1);
            issue_valid = (i == 0); issue_rd = 5'd3; step();
        end
        drain();

        // unexpected result, sticky across flush, cleared by reset
        f_rs1 = 5'd7;
        do_res(5'd7, 32'h40000000, 5'b00000);
        idle(); repeat (4) step();
        idle(); flush = 1'b1; step();
        idle(); repeat (2) step();
        idle(); RST = 1'b1; step();
        idle(); step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            RST = ($urandom_range(0, 399) == 0);
            flush = ($urandom_range(0, 99) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_rd = 5'($urandom_range(0, 7));
            f_rs1 = 5'($urandom_range(0, 7));
            f_rs2 = 5'($urandom_range(0, 7));
            res_data = $urandom;
            res_flags = 5'($urandom);
            res_rd = 5'($urandom);
            if (fpuq.size() > 0 && $urandom_range(0, 1) == 1) begin
                res_valid = 1'b1; res_rd = 5'(fpuq[0]);
            end else if (fpuq.size() == 0 && outs == 0 && pend == '0
                         && $urandom_range(0, 49) == 0) begin
                res_valid = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
